// File: rtl/rtc_bus_burst_ctrl_if.sv
// Handshake, burst-request and RTC strobe bundle for rtc_bus_burst_ctrl.
// Wiring only, no latency.
// No backpressure: start is a request level, the controller signals acceptance through busy.
interface rtc_bus_burst_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              i_start;
    logic              i_rw;
    logic [DATA_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_take;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_busy;
    logic              o_done;
    logic              o_a_d_n;
    logic              o_cs_n;
    logic              o_rd_n;
    logic              o_wr_n;

    // Requester side: issues bursts and supplies write words.
    modport master (
        output i_start, i_rw, i_addr, i_len, i_wr_data,
        input  o_wr_take, o_rd_data, o_rd_valid, o_busy, o_done,
        input  o_a_d_n, o_cs_n, o_rd_n, o_wr_n
    );

    // Controller side.
    modport slave (
        input  i_start, i_rw, i_addr, i_len, i_wr_data,
        output o_wr_take, o_rd_data, o_rd_valid, o_busy, o_done,
        output o_a_d_n, o_cs_n, o_rd_n, o_wr_n
    );
endinterface

// File: rtl/rtc_bus_burst_ctrl.sv
// Burst controller for a multiplexed address/data RTC bus; RTC_BURST_AUTOINC_EN enables multi-element bursts.
// Latency: ALE one cycle after start is accepted, 4+T_ADDR+T_TURN+T_DATA cycles per element, plus one DONE cycle.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module rtc_bus_burst_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int T_ADDR = 4,
    parameter int T_TURN = 8,
    parameter int T_DATA = 4
) (
    input  logic                clk,
    input  logic                reset,
    rtc_bus_burst_ctrl_if.slave bus_if,
    inout  wire  [DATA_W-1:0]   io_ad_bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ALE, S_ADDR_WR, S_ADDR_END, S_TURN,
        S_DATA, S_DATA_END, S_NEXT, S_DONE
    } state_t;

    localparam logic [3:0] P_ADDR_LAST = 4'(T_ADDR - 1);
    localparam logic [3:0] P_TURN_LAST = 4'(T_TURN - 1);
    localparam logic [3:0] P_DATA_LAST = 4'(T_DATA - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_phase;

    logic              r_rw;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              w_rw_eff;
    logic              w_more;

    logic              r_a_d_n, r_cs_n, r_rd_n, r_wr_n;
    logic              r_busy, r_done, r_wr_take, r_ad_oe;
    logic [DATA_W-1:0] r_ad_out;

    logic              w_a_d_n, w_cs_n, w_rd_n, w_wr_n;
    logic              w_busy, w_done, w_wr_take, w_ad_oe;
    logic [DATA_W-1:0] w_ad_out;

    // The direction is only known from the input in the accepting cycle.
    assign w_rw_eff = (r_state == S_IDLE) ? bus_if.i_rw : r_rw;

`ifdef RTC_BURST_AUTOINC_EN
    logic [LEN_W-1:0] r_rem;

    // Elements still to run, including the current one; len=0 counts as one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem <= '0;
        end else if (r_state == S_IDLE && bus_if.i_start) begin
            r_rem <= (bus_if.i_len == '0) ? LEN_W'(1) : bus_if.i_len;
        end else if (r_state == S_NEXT) begin
            r_rem <= r_rem - LEN_W'(1);
        end
    end

    assign w_more = (r_rem > LEN_W'(1));
`else
    assign w_more = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; timed states leave on the last phase count.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (bus_if.i_start) w_state_nxt = S_ALE;
            S_ALE:      w_state_nxt = S_ADDR_WR;
            S_ADDR_WR:  if (r_phase == P_ADDR_LAST) w_state_nxt = S_ADDR_END;
            S_ADDR_END: w_state_nxt = S_TURN;
            S_TURN:     if (r_phase == P_TURN_LAST) w_state_nxt = S_DATA;
            S_DATA:     if (r_phase == P_DATA_LAST) w_state_nxt = S_DATA_END;
            S_DATA_END: w_state_nxt = S_NEXT;
            S_NEXT:     w_state_nxt = w_more ? S_ALE : S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Shared phase counter, cleared whenever a new state is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (w_state_nxt != r_state) begin
            r_phase <= '0;
        end else if (r_state == S_ADDR_WR || r_state == S_TURN || r_state == S_DATA) begin
            r_phase <= r_phase + 4'd1;
        end
    end

    // Request latch, per-element write word and address increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (r_state == S_IDLE && bus_if.i_start) begin
                r_rw   <= bus_if.i_rw;
                r_addr <= bus_if.i_addr;
            end
            if (r_state == S_ALE) r_wdata <= bus_if.i_wr_data;
            if (r_state == S_NEXT) r_addr <= r_addr + DATA_W'(1);
        end
    end

    // Read capture on the last data cycle; presented during DATA_END.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (r_state == S_DATA && r_phase == P_DATA_LAST && !r_rw) begin
                r_rd_data  <= io_ad_bus;
                r_rd_valid <= 1'b1;
            end
        end
    end

    // Output decode from the upcoming state so every output can be a flop.
    always_comb begin
        w_a_d_n   = 1'b1;
        w_cs_n    = 1'b1;
        w_rd_n    = 1'b1;
        w_wr_n    = 1'b1;
        w_ad_oe   = 1'b0;
        w_ad_out  = r_addr;
        w_busy    = (w_state_nxt != S_IDLE);
        w_done    = 1'b0;
        w_wr_take = 1'b0;
        case (w_state_nxt)
            S_ALE: begin
                w_a_d_n   = 1'b0;
                w_wr_take = w_rw_eff;
            end
            S_ADDR_WR: begin
                w_a_d_n = 1'b0;
                w_cs_n  = 1'b0;
                w_wr_n  = 1'b0;
                w_ad_oe = 1'b1;
            end
            S_ADDR_END: begin
                w_a_d_n = 1'b0;
                w_ad_oe = 1'b1;
            end
            S_DATA: begin
                w_cs_n = 1'b0;
                if (w_rw_eff) begin
                    w_wr_n   = 1'b0;
                    w_ad_oe  = 1'b1;
                    w_ad_out = r_wdata;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            S_DATA_END: begin
                if (w_rw_eff) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = r_wdata;
                end
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Output flops; reset forces the bus released and every strobe inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_d_n   <= 1'b1;
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ad_oe   <= 1'b0;
            r_ad_out  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_take <= 1'b0;
        end else begin
            r_a_d_n   <= w_a_d_n;
            r_cs_n    <= w_cs_n;
            r_rd_n    <= w_rd_n;
            r_wr_n    <= w_wr_n;
            r_ad_oe   <= w_ad_oe;
            r_ad_out  <= w_ad_out;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_wr_take <= w_wr_take;
        end
    end

    assign io_ad_bus         = r_ad_oe ? r_ad_out : {DATA_W{1'bz}};
    assign bus_if.o_a_d_n    = r_a_d_n;
    assign bus_if.o_cs_n     = r_cs_n;
    assign bus_if.o_rd_n     = r_rd_n;
    assign bus_if.o_wr_n     = r_wr_n;
    assign bus_if.o_busy     = r_busy;
    assign bus_if.o_done     = r_done;
    assign bus_if.o_wr_take  = r_wr_take;
    assign bus_if.o_rd_data  = r_rd_data;
    assign bus_if.o_rd_valid = r_rd_valid;
endmodule

// File: tb/tb_rtc_bus_burst_ctrl.sv
`timescale 1ns/1ps
module tb_rtc_bus_burst_ctrl;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;
    localparam int T_ADDR = 4;
    localparam int T_TURN = 8;
    localparam int T_DATA = 4;
    // One element occupies ALE, ADDR_WR, ADDR_END, TURN, DATA, DATA_END, NEXT.
    localparam int ELEM   = 4 + T_ADDR + T_TURN + T_DATA;
`ifdef RTC_BURST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    wire [DATA_W-1:0] ad_bus;
    rtc_bus_burst_ctrl_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bif ();

    rtc_bus_burst_ctrl #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .T_ADDR(T_ADDR), .T_TURN(T_TURN), .T_DATA(T_DATA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_if   (bif),
        .io_ad_bus(ad_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues filled by stimulus, drained by the monitor.
    exp_t       q_take[$];
    exp_t       q_addr[$];
    exp_t       q_wdat[$];
    exp_t       q_rd[$];
    int         q_done[$];
    logic [7:0] q_src[$];
    logic [7:0] ref_mem [256];

    function automatic logic [7:0] init_val(input int i);
        return (i == 'h0A) ? 8'h5C : 8'(i * 29 + 7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // RTC device model: latches the address, stores writes, drives reads.
    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_addr = 8'h00;
    bit         rtc_init = 1'b0;
    wire        rtc_drv  = !bif.o_cs_n && !bif.o_rd_n && bif.o_a_d_n;
    assign ad_bus = rtc_drv ? rtc_mem[rtc_addr] : 8'bz;

    always @(posedge clk) begin
        if (!rtc_init) begin
            for (int i = 0; i < 256; i++) rtc_mem[i] <= init_val(i);
            rtc_init <= 1'b1;
        end else begin
            if (!bif.o_a_d_n && !bif.o_cs_n && !bif.o_wr_n) rtc_addr <= ad_bus;
            if (bif.o_a_d_n && !bif.o_cs_n && !bif.o_wr_n) rtc_mem[rtc_addr] <= ad_bus;
        end
    end

    // Monitor: pops expectations whenever the DUT shows an event.
    int         run_a = 0, run_w = 0, run_r = 0;
    bit         take_prev = 1'b0;
    logic [7:0] cur_a = 8'h00, cur_w = 8'h00;
    exp_t       e;

    always @(negedge clk) begin
        if (reset) begin
            run_a = 0; run_w = 0; run_r = 0; take_prev = 1'b0;
        end else begin
            if (take_prev && q_src.size() > 0) void'(q_src.pop_front());
            take_prev = bif.o_wr_take;
            bif.i_wr_data = (q_src.size() > 0) ? q_src[0] : 8'($urandom);

            if (bif.o_wr_take) begin
                if (q_take.size() == 0) unexpected("wr_take");
                else begin e = q_take.pop_front(); check("wr_take_cycle", cyc, e.cyc); end
            end

            if (!bif.o_a_d_n && !bif.o_cs_n && !bif.o_wr_n) begin
                if (run_a == 0) begin
                    if (q_addr.size() == 0) unexpected("addr_phase");
                    else begin e = q_addr.pop_front(); check("addr_cycle", cyc, e.cyc); cur_a = e.val; end
                end
                check("addr_value", ad_bus, cur_a);
                run_a++;
            end else if (run_a != 0) begin
                check("addr_len", run_a, T_ADDR);
                run_a = 0;
            end

            if (bif.o_a_d_n && !bif.o_cs_n && !bif.o_wr_n) begin
                if (run_w == 0) begin
                    if (q_wdat.size() == 0) unexpected("wr_phase");
                    else begin e = q_wdat.pop_front(); check("wr_cycle", cyc, e.cyc); cur_w = e.val; end
                end
                check("wr_bus", ad_bus, cur_w);
                run_w++;
            end else if (run_w != 0) begin
                check("wr_len", run_w, T_DATA);
                run_w = 0;
            end

            if (!bif.o_cs_n && !bif.o_rd_n) begin
                check("rd_strobe_ale", bif.o_a_d_n, 1);
                run_r++;
            end else if (run_r != 0) begin
                check("rd_len", run_r, T_DATA);
                run_r = 0;
            end

            if (bif.o_rd_valid) begin
                if (q_rd.size() == 0) unexpected("rd_valid");
                else begin
                    e = q_rd.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_data", bif.o_rd_data, e.val);
                end
            end

            if (bif.o_done) begin
                done_cnt++;
                if (q_done.size() == 0) unexpected("done");
                else check("done_cycle", cyc, q_done.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (bif.o_busy && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) unexpected("busy_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Push the expected events of the elements [0, upto) starting at cycle m.
    task automatic expect_elems(input bit rw, input logic [7:0] addr, input int m,
                                input int upto, input logic [7:0] w0, input bit addr_only_last);
        logic [7:0] a, w;
        for (int j = 0; j < upto; j++) begin
            a = 8'(addr + j);
            if (rw) q_take.push_back('{m + 1 + ELEM * j, 8'h00});
            q_addr.push_back('{m + 2 + ELEM * j, a});
            if (addr_only_last && j == upto - 1) begin
                if (rw) q_src.push_back(8'($urandom));
            end else if (rw) begin
                w = (j == 0) ? w0 : 8'($urandom);
                q_src.push_back(w);
                q_wdat.push_back('{m + 3 + T_ADDR + T_TURN + ELEM * j, w});
                ref_mem[a] = w;
            end else begin
                q_rd.push_back('{m + 3 + T_ADDR + T_TURN + T_DATA + ELEM * j, ref_mem[a]});
            end
        end
    endtask

    task automatic run_txn(input bit rw, input logic [7:0] addr, input logic [3:0] len,
                           input logic [7:0] w0, input bit repulse);
        int k, m;
        k = AUTOINC ? ((len == 0) ? 1 : int'(len)) : 1;
        wait_idle();
        m = cyc;
        expect_elems(rw, addr, m, k, w0, 1'b0);
        q_done.push_back(m + 1 + ELEM * k);
        bif.i_start = 1'b1; bif.i_rw = rw; bif.i_addr = addr; bif.i_len = len;
        @(negedge clk);
        bif.i_start = 1'b0;
        bif.i_rw = ~rw; bif.i_addr = 8'($urandom); bif.i_len = 4'($urandom);
        check("busy_after_start", bif.o_busy, 1);
        if (repulse) begin
            repeat (3) @(negedge clk);
            bif.i_start = 1'b1; bif.i_len = 4'd15;
            @(negedge clk);
            bif.i_start = 1'b0;
        end
        wait_idle();
        check("busy_idle", bif.o_busy, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_d_n"}, bif.o_a_d_n, 1);
        check({tag, "_cs_n"}, bif.o_cs_n, 1);
        check({tag, "_rd_n"}, bif.o_rd_n, 1);
        check({tag, "_wr_n"}, bif.o_wr_n, 1);
        check({tag, "_busy"}, bif.o_busy, 0);
        check({tag, "_done"}, bif.o_done, 0);
        check({tag, "_wr_take"}, bif.o_wr_take, 0);
        check({tag, "_rd_valid"}, bif.o_rd_valid, 0);
        check({tag, "_rd_data"}, bif.o_rd_data, 0);
    endtask

    // len=4 write aborted in TURN of the second element (first when bursts are off).
    task automatic reset_mid_burst();
        int m, ab, done_before;
        logic [7:0] addr;
        addr = 8'h50;
        ab = AUTOINC ? 1 : 0;
        wait_idle();
        m = cyc;
        expect_elems(1'b1, addr, m, ab + 1, 8'hA5, 1'b1);
        done_before = done_cnt;
        bif.i_start = 1'b1; bif.i_rw = 1'b1; bif.i_addr = addr; bif.i_len = 4'd4;
        @(negedge clk);
        bif.i_start = 1'b0;
        while (cyc < m + 5 + T_ADDR + ELEM * ab) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_state("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("no_done_after_abort", done_cnt, done_before);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bif.i_start = 1'b0; bif.i_rw = 1'b0; bif.i_addr = '0; bif.i_len = '0;
        repeat (3) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        run_txn(1'b0, 8'h0A, 4'd1, 8'h00, 1'b0);
        run_txn(1'b1, 8'h04, 4'd1, 8'h37, 1'b0);
        run_txn(1'b0, 8'h04, 4'd1, 8'h00, 1'b0);
        run_txn(1'b0, 8'hFE, 4'd3, 8'h00, 1'b0);
        reset_mid_burst();
        run_txn(1'b0, 8'h50, 4'd2, 8'h00, 1'b0);
        run_txn(1'b1, 8'h20, 4'd0, 8'h11, 1'b1);
        run_txn(1'b0, 8'h20, 4'd5, 8'h00, 1'b1);
        for (int t = 0; t < 12; t++)
            run_txn(1'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));

        check("queues_drained",
              q_take.size() + q_addr.size() + q_wdat.size() + q_rd.size() + q_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end
endmodule
